misr_check_sequencer: RTL
=========================

// Module: misr_check_sequencer
// PURPOSE
//  Sequences one signature-check run around a DUT/neighbour pair with MISR compaction.
//  - Puts the DUT and MISRs in reset, then enables the stimulus LFSR for a programmed number of cycles.
//  - Optionally fires a one-cycle error injection at one flip-flop site.
//  - Drains the pipeline, then compares the observed MISR signature against an expected value.
//  - Sits between the test harness (start/config) and the DUT wrapper (reset, stim enable, inj_e).
// PARAMETERS
//  NUM_SITES  8  number of injectable FF sites (width of inj_e)
//  SITE_W     4  width of inj_site; values >= NUM_SITES mean "no injection"
//  MISR_W     6  signature width
//  CYC_W      8  width of run_len / inj_cycle counters
//  DRAIN_CYC  3  post-stimulus flush cycles (DUT+neighbour register depth)
// PORTS
//  clk        in   1          clock, all state on posedge
//  rst        in   1          reset, synchronous, active-high
//  start      in   1          pulse; accepted only in IDLE
//  abort      in   1          pulse; terminates any active run
//  run_len    in   CYC_W      stimulus cycles for this run
//  inj_site   in   SITE_W     binary site index to inject
//  inj_cycle  in   CYC_W      RUN-cycle index (0-based) at which to inject
//  exp_sig    in   MISR_W     expected final signature
//  obs_sig    in   MISR_W     observed MISR signature from the DUT wrapper
//  dut_rst    out  1          reset to DUT/neighbour FFs
//  misr_rst   out  1          reset to all MISRs (seed 1)
//  stim_en    out  1          advance stimulus LFSR / drive a,b
//  inj_e      out  NUM_SITES  one-hot injection enable, at most one bit set
//  busy       out  1          high in every state except IDLE
//  done       out  1          one-cycle pulse when a run ends
//  pass       out  1          result; valid from done, held until the next accepted start
//  aborted    out  1          set with done if the run ended via abort; held like pass
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: dut_rst=1, misr_rst=1, stim_en=0, inj_e=0, busy=0, done=0, pass=0, aborted=0; state=IDLE.
//  - FSM states IDLE, RESET, RUN, DRAIN, CHECK:
//    - IDLE: dut_rst=misr_rst=1.
//      - On start: latch run_len, inj_site, inj_cycle, exp_sig into config registers.
//      - Clear pass and aborted; go to RESET.
//    - RESET: hold dut_rst=misr_rst=1 for exactly 2 cycles, then go to RUN (or to DRAIN if latched run_len==0).
//    - RUN: dut_rst=misr_rst=0, stim_en=1. Cycle counter counts 0..run_len-1, then go to DRAIN.
//    - DRAIN: stim_en=0, MISRs keep compacting. Stay DRAIN_CYC cycles, then go to CHECK.
//    - CHECK: one cycle. pass<=(obs_sig==latched exp_sig), done<=1, then go to IDLE.
//  - Timing: with start accepted in cycle T, RUN occupies T+3..T+2+run_len and done is high in cycle T+3+run_len+DRAIN_CYC.
//  - Injection: inj_e = one-hot(latched inj_site) for exactly the single RUN cycle where counter==inj_cycle.
//    - inj_e stays 0 if inj_site>=NUM_SITES or inj_cycle>=run_len.
//    - inj_e is never asserted outside RUN.
//  - start while busy is ignored. Config inputs are ignored except in the start-accept cycle.
//  - abort in any non-IDLE state: next cycle IDLE with stim_en=0, inj_e=0, dut_rst=misr_rst=1, done=1, pass=0, aborted=1.
//  - abort in IDLE has no effect. abort and start together in IDLE: start wins.
//  - rst mid-run: all outputs take their reset values next cycle, no done pulse, config registers are discarded.
//  - Counter width is CYC_W. Compares are unsigned and the counter never wraps (run_len <= 2^CYC_W-1).
// STRUCTURE
//  - Package misr_check_pkg: state enum type, SITE_NONE constant (= NUM_SITES), RESET_HOLD=2.
//  - Sub-module inj_site_decoder: SITE_W binary + enable -> NUM_SITES one-hot, all-zero when out of range (combinational).
//  - Top module: FSM, config registers, cycle/drain counters, compare.
// TESTING
//  1. run_len=6, inj_site=8, exp_sig=golden -> done at T+12 (DRAIN_CYC=3), pass=1, inj_e==0 throughout.
//  2. run_len=6, inj_site=3, inj_cycle=2 -> inj_e==8'h08 only in cycle T+5; mismatching exp_sig gives pass=0.
//  3. inj_site=2, inj_cycle=10, run_len=6 -> inj_e never asserted; inj_site=9 -> never asserted.
//  4. start pulsed at T+4 with new run_len=1 -> ignored, done still at T+12; run_len=0 -> done at T+6.
//  5. abort at T+5 (RUN) -> T+6: busy=0, stim_en=0, done=1, pass=0, aborted=1.
//  6. rst asserted at T+5 -> T+6: reset values, no done; a subsequent start runs normally.

Source files
------------

// File: rtl/misr_check_pkg.sv
// rtl/misr_check_pkg.sv - shared constants and FSM encoding for the MISR check sequencer
package misr_check_pkg;

  localparam int DEF_NUM_SITES = 8;
  localparam int DEF_SITE_W    = 4;
  localparam int DEF_MISR_W    = 6;
  localparam int DEF_CYC_W     = 8;
  localparam int DEF_DRAIN_CYC = 3;

  // Any inj_site at or above this value disables injection for the run.
  localparam int SITE_NONE  = DEF_NUM_SITES;
  localparam int RESET_HOLD = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RESET = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_CHECK = 3'd4;

endpackage

// File: rtl/misr_check_sequencer_if.sv
// rtl/misr_check_sequencer_if.sv - harness/DUT-wrapper bundle seen by the check sequencer
interface misr_check_sequencer_if
  import misr_check_pkg::*;
#(
  parameter int NUM_SITES = DEF_NUM_SITES,
  parameter int SITE_W    = DEF_SITE_W,
  parameter int MISR_W    = DEF_MISR_W,
  parameter int CYC_W     = DEF_CYC_W
) ();

  logic                 start;
  logic                 abort;
  logic [CYC_W-1:0]     run_len;
  logic [SITE_W-1:0]    inj_site;
  logic [CYC_W-1:0]     inj_cycle;
  logic [MISR_W-1:0]    exp_sig;
  logic [MISR_W-1:0]    obs_sig;
  logic                 dut_rst;
  logic                 misr_rst;
  logic                 stim_en;
  logic [NUM_SITES-1:0] inj_e;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 aborted;

  modport master (
    output start, abort, run_len, inj_site, inj_cycle, exp_sig, obs_sig,
    input  dut_rst, misr_rst, stim_en, inj_e, busy, done, pass, aborted
  );

  modport slave (
    input  start, abort, run_len, inj_site, inj_cycle, exp_sig, obs_sig,
    output dut_rst, misr_rst, stim_en, inj_e, busy, done, pass, aborted
  );

endinterface

// File: rtl/misr_check_sequencer_inj_site_decoder.sv
// rtl/misr_check_sequencer_inj_site_decoder.sv - binary site index to one-hot injection enable
module inj_site_decoder #(
  parameter int NUM_SITES = 8,
  parameter int SITE_W    = 4
) (
  input  logic [SITE_W-1:0]    site,
  input  logic                 en,
  output logic [NUM_SITES-1:0] onehot
);

  // Out-of-range indices simply never match a site, giving all-zero.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SITES; i++) begin
      onehot[i] = en && (site == SITE_W'(i));
    end
  end

endmodule

// File: rtl/misr_check_sequencer.sv
// rtl/misr_check_sequencer.sv - sequences reset, stimulus, optional injection, drain and signature compare
module misr_check_sequencer
  import misr_check_pkg::*;
#(
  parameter int NUM_SITES = DEF_NUM_SITES,
  parameter int SITE_W    = DEF_SITE_W,
  parameter int MISR_W    = DEF_MISR_W,
  parameter int CYC_W     = DEF_CYC_W,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
  input logic                   clk,
  input logic                   rst,
  misr_check_sequencer_if.slave bus
);

  state_t               state_q, state_d;
  logic [CYC_W-1:0]     cnt_q, cnt_d;
  logic [CYC_W-1:0]     run_len_q, run_len_d;
  logic [SITE_W-1:0]    inj_site_q, inj_site_d;
  logic [CYC_W-1:0]     inj_cycle_q, inj_cycle_d;
  logic [MISR_W-1:0]    exp_sig_q, exp_sig_d;
  logic                 dut_rst_q, dut_rst_d;
  logic                 misr_rst_q, misr_rst_d;
  logic                 stim_en_q, stim_en_d;
  logic [NUM_SITES-1:0] inj_e_q, inj_e_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 aborted_q, aborted_d;
  logic                 inj_hit;

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_len_d   = run_len_q;
    inj_site_d  = inj_site_q;
    inj_cycle_d = inj_cycle_q;
    exp_sig_d   = exp_sig_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    aborted_d   = aborted_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          run_len_d   = bus.run_len;
          inj_site_d  = bus.inj_site;
          inj_cycle_d = bus.inj_cycle;
          exp_sig_d   = bus.exp_sig;
          pass_d      = 1'b0;
          aborted_d   = 1'b0;
          cnt_d       = '0;
          state_d     = ST_RESET;
        end
      end
      ST_RESET: begin
        if (cnt_q == CYC_W'(RESET_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = (run_len_q == '0) ? ST_DRAIN : ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if ((cnt_q + 1'b1) == run_len_q) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // The last drain cycle already carries the final signature, so compare here.
        if (cnt_q == CYC_W'(DRAIN_CYC - 1)) begin
          cnt_d   = '0;
          pass_d  = (bus.obs_sig == exp_sig_q);
          done_d  = 1'b1;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      aborted_d = 1'b1;
    end

    dut_rst_d  = (state_d == ST_IDLE) || (state_d == ST_RESET);
    misr_rst_d = dut_rst_d;
    stim_en_d  = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
    inj_hit    = (state_d == ST_RUN) && (cnt_d == inj_cycle_q);
  end

  inj_site_decoder #(
    .NUM_SITES (NUM_SITES),
    .SITE_W    (SITE_W)
  ) u_inj_site_decoder (
    .site   (inj_site_q),
    .en     (inj_hit),
    .onehot (inj_e_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      run_len_q   <= '0;
      inj_site_q  <= '0;
      inj_cycle_q <= '0;
      exp_sig_q   <= '0;
      dut_rst_q   <= 1'b1;
      misr_rst_q  <= 1'b1;
      stim_en_q   <= 1'b0;
      inj_e_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_len_q   <= run_len_d;
      inj_site_q  <= inj_site_d;
      inj_cycle_q <= inj_cycle_d;
      exp_sig_q   <= exp_sig_d;
      dut_rst_q   <= dut_rst_d;
      misr_rst_q  <= misr_rst_d;
      stim_en_q   <= stim_en_d;
      inj_e_q     <= inj_e_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      aborted_q   <= aborted_d;
    end
  end

  assign bus.dut_rst  = dut_rst_q;
  assign bus.misr_rst = misr_rst_q;
  assign bus.stim_en  = stim_en_q;
  assign bus.inj_e    = inj_e_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.aborted  = aborted_q;

endmodule
